// File: rtl/cpu_bus_cycle_ctrl.sv
// cpu_bus_cycle_ctrl: 68000 bus cycle sequencer (cs decode in, sdr_req/sdr_ack handshake, registered dtack_n/berr_n/busy out)
module cpu_bus_cycle_ctrl #(
  parameter int FAST_WAIT    = 2,
  parameter int SOUND_WAIT   = 4,
  parameter int BERR_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_ce,
  input  logic       cpu_as_n,
  input  logic [1:0] cpu_ds_n,
  input  logic       cpu_rw,
  input  logic       pause,
  input  logic       rom_cs_n,
  input  logic       work_cs_n,
  input  logic       fast_cs_n,
  input  logic       sound_cs_n,
  input  logic       ss_cs_n,
  output logic       sdr_req,
  output logic       sdr_we,
  input  logic       sdr_ack,
  output logic       cpu_dtack_n,
  output logic       cpu_berr_n,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, WAIT_FIX, WAIT_SDR, DRAIN, ACK, BERR} state_t;
  state_t state, state_nx, dec_state;
  logic [7:0] cnt, cnt_nx, dec_cnt;
  logic unmapped, unmapped_nx, dec_unmapped;
  logic rw, rw_nx, dec_rw;
  logic we_nx, dec_we;
  logic dtack_d, berr_d, req_d, busy_d;
  logic any_cs, start;
  assign any_cs = ~&{ss_cs_n, rom_cs_n, work_cs_n, sound_cs_n, fast_cs_n};
  assign start  = !cpu_as_n && !(&cpu_ds_n) && !pause;
  always_comb begin
    dec_rw       = (state == IDLE) ? cpu_rw : rw;
    dec_state    = WAIT_FIX;
    dec_cnt      = 8'(BERR_TIMEOUT);
    dec_unmapped = 1'b1;
    dec_we       = 1'b0;
    if (!ss_cs_n) begin
      dec_state    = ACK;
      dec_cnt      = '0;
      dec_unmapped = 1'b0;
    end else if (!rom_cs_n) begin
      dec_state    = dec_rw ? WAIT_SDR : ACK;
      dec_cnt      = '0;
      dec_unmapped = 1'b0;
    end else if (!work_cs_n) begin
      dec_state    = WAIT_SDR;
      dec_cnt      = '0;
      dec_unmapped = 1'b0;
      dec_we       = !dec_rw;
    end else if (!sound_cs_n) begin
      dec_state    = (SOUND_WAIT == 0) ? ACK : WAIT_FIX;
      dec_cnt      = 8'(SOUND_WAIT);
      dec_unmapped = 1'b0;
    end else if (!fast_cs_n) begin
      dec_state    = (FAST_WAIT == 0) ? ACK : WAIT_FIX;
      dec_cnt      = 8'(FAST_WAIT);
      dec_unmapped = 1'b0;
    end
  end
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    unmapped_nx = unmapped;
    rw_nx       = rw;
    we_nx       = sdr_we;
    case (state)
      IDLE: if (start) begin
        state_nx    = dec_state;
        cnt_nx      = dec_cnt;
        unmapped_nx = dec_unmapped;
        rw_nx       = cpu_rw;
        we_nx       = dec_we;
      end
      WAIT_FIX:
        if (cpu_as_n) state_nx = IDLE;
        else if (unmapped && any_cs) begin
          state_nx    = dec_state;
          cnt_nx      = dec_cnt;
          unmapped_nx = dec_unmapped;
          we_nx       = dec_we;
        end else if (cnt == '0) state_nx = unmapped ? BERR : ACK;
        else if (cpu_ce) cnt_nx = cnt - 8'd1;
      WAIT_SDR:
        if (sdr_req && sdr_ack) state_nx = cpu_as_n ? IDLE : ACK;
        else if (cpu_as_n) state_nx = DRAIN;
      DRAIN: if (sdr_req && sdr_ack) state_nx = IDLE;
      ACK, BERR: if (cpu_as_n) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    dtack_d = state_nx != ACK;
    berr_d  = state_nx != BERR;
    req_d   = state_nx == WAIT_SDR || state_nx == DRAIN;
    busy_d  = state_nx != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      unmapped    <= 1'b0;
      rw          <= 1'b1;
      sdr_we      <= 1'b0;
      sdr_req     <= 1'b0;
      cpu_dtack_n <= 1'b1;
      cpu_berr_n  <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      unmapped    <= unmapped_nx;
      rw          <= rw_nx;
      sdr_we      <= we_nx;
      sdr_req     <= req_d;
      cpu_dtack_n <= dtack_d;
      cpu_berr_n  <= berr_d;
      busy        <= busy_d;
    end
  end
endmodule

// File: tb/tb_cpu_bus_cycle_ctrl.sv
// tb_cpu_bus_cycle_ctrl: directed plus randomized bus cycles checked against a timing model
module tb_cpu_bus_cycle_ctrl;
  localparam int FW = 2, SW = 4, BT = 4;
  logic clk = 0, reset = 1, cpu_ce = 0, cpu_as_n = 1, cpu_rw = 1, pause = 0, sdr_ack = 0;
  logic [1:0] cpu_ds_n = 2'b11;
  logic [4:0] cs_n = 5'b11111;
  logic sdr_req, sdr_we, cpu_dtack_n, cpu_berr_n, busy;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  cpu_bus_cycle_ctrl #(.FAST_WAIT(FW), .SOUND_WAIT(SW), .BERR_TIMEOUT(BT)) dut (
    .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .cpu_as_n(cpu_as_n), .cpu_ds_n(cpu_ds_n),
    .cpu_rw(cpu_rw), .pause(pause), .rom_cs_n(cs_n[3]), .work_cs_n(cs_n[2]),
    .fast_cs_n(cs_n[0]), .sound_cs_n(cs_n[1]), .ss_cs_n(cs_n[4]), .sdr_req(sdr_req),
    .sdr_we(sdr_we), .sdr_ack(sdr_ack), .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n),
    .busy(busy));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    chk("excl", {31'b0, cpu_dtack_n | cpu_berr_n}, 1);
  endtask
  function automatic int kind_of(input logic [4:0] m);
    for (int i = 0; i < 5; i++) if (!m[4-i]) return i;
    return 5;
  endfunction
  task automatic bus_cycle(input logic [4:0] m, input bit rw, input int cep, input int ackd, input int hold);
    int kind, w, resp;
    bit sdr, berr;
    kind = kind_of(m);
    sdr  = (kind == 1 && rw) || kind == 2;
    berr = kind == 5;
    w    = kind == 3 ? SW : kind == 4 ? FW : BT;
    resp = (kind == 0 || (kind == 1 && !rw)) ? 0 : sdr ? ackd : (w == 0 ? 0 : w * cep + 1);
    cs_n = m;
    cpu_rw = rw;
    cpu_ds_n = 2'($urandom_range(0, 2));
    cpu_as_n = 0;
    pause = 0;
    for (int k = 0; k <= resp + hold; k++) begin
      cpu_ce = (k % cep) == 0;
      sdr_ack = sdr && k == ackd;
      if (k > 0) pause = 1'($urandom_range(0, 1));
      tick;
      chk("dtack", cpu_dtack_n, !(!berr && k >= resp));
      chk("berr", cpu_berr_n, !(berr && k >= resp));
      chk("req", sdr_req, sdr && k < resp);
      chk("busy", busy, 1);
      if (sdr && k < resp) chk("we", sdr_we, kind == 2 && !rw);
    end
    cpu_as_n = 1;
    sdr_ack = 0;
    cs_n = 5'h1f;
    pause = 0;
    cpu_ce = 1;
    tick;
    chk("rel_dtack", cpu_dtack_n, 1);
    chk("rel_berr", cpu_berr_n, 1);
    chk("rel_busy", busy, 0);
    tick;
    chk("idle_busy", busy, 0);
  endtask
  initial begin
    tick;
    tick;
    chk("rst_dtack", cpu_dtack_n, 1);
    chk("rst_berr", cpu_berr_n, 1);
    chk("rst_req", sdr_req, 0);
    chk("rst_we", sdr_we, 0);
    chk("rst_busy", busy, 0);
    reset = 0;
    tick;
    bus_cycle(5'b11110, 1, 1, 0, 2);
    bus_cycle(5'b11011, 0, 1, 5, 1);
    bus_cycle(5'b10111, 0, 1, 0, 1);
    bus_cycle(5'b11111, 1, 2, 0, 1);
    bus_cycle(5'b01111, 0, 1, 0, 0);
    bus_cycle(5'b11101, 1, 1, 0, 1);
    bus_cycle(5'b10111, 1, 1, 1, 0);
    bus_cycle(5'b00000, 1, 1, 0, 0);
    cs_n = 5'b11110; cpu_ds_n = 2'b00; cpu_as_n = 0; cpu_ce = 1;
    tick;
    chk("ab_fix_busy0", busy, 1);
    tick;
    tick;
    cpu_as_n = 1;
    tick;
    chk("ab_fix_busy", busy, 0);
    chk("ab_fix_dtack", cpu_dtack_n, 1);
    repeat (3) begin
      tick;
      chk("ab_fix_dtack_later", cpu_dtack_n, 1);
    end
    cs_n = 5'b11011; cpu_rw = 1; cpu_as_n = 0;
    tick;
    chk("ab_sdr_req0", sdr_req, 1);
    cpu_as_n = 1;
    tick;
    chk("ab_sdr_req1", sdr_req, 1);
    chk("ab_sdr_busy1", busy, 1);
    chk("ab_sdr_dtack1", cpu_dtack_n, 1);
    tick;
    chk("ab_sdr_req2", sdr_req, 1);
    sdr_ack = 1;
    tick;
    sdr_ack = 0;
    chk("ab_sdr_req3", sdr_req, 0);
    chk("ab_sdr_busy3", busy, 0);
    chk("ab_sdr_dtack3", cpu_dtack_n, 1);
    tick;
    chk("ab_sdr_dtack4", cpu_dtack_n, 1);
    cpu_as_n = 0;
    tick;
    chk("rs_req0", sdr_req, 1);
    reset = 1;
    tick;
    chk("rs_req1", sdr_req, 0);
    chk("rs_busy1", busy, 0);
    reset = 0; cpu_as_n = 1; cs_n = 5'h1f; sdr_ack = 1;
    tick;
    sdr_ack = 0;
    chk("rs_dtack", cpu_dtack_n, 1);
    chk("rs_req2", sdr_req, 0);
    chk("rs_busy2", busy, 0);
    pause = 1; cs_n = 5'b11110; cpu_as_n = 0; cpu_ds_n = 2'b10;
    repeat (3) begin
      tick;
      chk("pause_busy", busy, 0);
    end
    pause = 0;
    tick;
    chk("unpause_busy", busy, 1);
    cpu_as_n = 1;
    tick;
    chk("unpause_end", busy, 0);
    cpu_ds_n = 2'b11; cpu_as_n = 0;
    tick;
    chk("ds_idle_busy", busy, 0);
    cpu_as_n = 1;
    tick;
    cs_n = 5'h1f; cpu_ds_n = 2'b01; cpu_as_n = 0; cpu_ce = 1;
    tick;
    tick;
    cs_n = 5'b11110;
    for (int k = 2; k <= 6; k++) begin
      tick;
      chk("restart_dtack", cpu_dtack_n, !(k >= 2 + FW + 1));
      chk("restart_berr", cpu_berr_n, 1);
    end
    cpu_as_n = 1; cs_n = 5'h1f;
    tick;
    chk("restart_end", busy, 0);
    repeat (40) begin
      logic [4:0] m;
      for (int i = 0; i < 5; i++) m[i] = $urandom_range(0, 2) != 0;
      bus_cycle(m, 1'($urandom_range(0, 1)), $urandom_range(1, 3), $urandom_range(1, 6), $urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
